// File: rtl/swing_collector_if.sv
// Stream bundle for the collector: 4-bit triple input side and word-wide output side.
interface swing_collector_if #(
   parameter int NIBBLES = 8
);
   localparam int W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_a;
   logic [3:0]   in_b;
   logic [3:0]   in_and;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_a;
   logic [W-1:0] out_b;
   logic [W-1:0] out_and;

   modport master (
      output in_valid, in_a, in_b, in_and, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_and
   );

   modport slave (
      input  in_valid, in_a, in_b, in_and, out_ready,
      output in_ready, out_valid, out_a, out_b, out_and
   );
endinterface

// File: rtl/swing_collector.sv
// Packs NIBBLES accepted (A, B, AND) nibble triples LSB-first into words behind a 2-entry FIFO.
// Define SWING_CHECK_EN to build the sticky AND-consistency checker driving err.
module swing_collector #(
   parameter int NIBBLES = 8
) (
   input  logic             clk,
   input  logic             reset,
   swing_collector_if.slave bus,
   output logic             err,
   input  logic             err_clr
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] n;
   } word_t;

   logic [CW-1:0]       cnt_reg;
   logic [3:0]          sh_a_reg   [NIBBLES-1];
   logic [3:0]          sh_b_reg   [NIBBLES-1];
   logic [3:0]          sh_and_reg [NIBBLES-1];
   logic [W-5:0]        sh_a;
   logic [W-5:0]        sh_b;
   logic [W-5:0]        sh_and;

   logic [1:0]          count_reg;
   logic [1:0]          count_next;
   word_t               head_reg;
   word_t               head_next;
   word_t               tail_reg;
   word_t               tail_next;
   word_t               word_in;

   logic                last;
   logic                full;
   logic                accept;
   logic                push;
   logic                pop;

   assign last   = (cnt_reg == LAST);
   assign full   = (count_reg == 2'd2);
   // Only the word-completing nibble can be blocked; partial nibbles always flow.
   assign bus.in_ready  = ~(last & full & ~bus.out_ready);
   assign accept        = bus.in_valid & bus.in_ready;
   assign push          = accept & last;
   assign bus.out_valid = (count_reg != 2'd0);
   assign pop           = bus.out_valid & bus.out_ready;

   assign bus.out_a   = head_reg.a;
   assign bus.out_b   = head_reg.b;
   assign bus.out_and = head_reg.n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (accept) begin
         cnt_reg <= last ? '0 : cnt_reg + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES - 1; gi++) begin : g_nib
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sh_a_reg[gi]   <= '0;
               sh_b_reg[gi]   <= '0;
               sh_and_reg[gi] <= '0;
            end else if (accept && cnt_reg == CW'(gi)) begin
               sh_a_reg[gi]   <= bus.in_a;
               sh_b_reg[gi]   <= bus.in_b;
               sh_and_reg[gi] <= bus.in_and;
            end
         end

         assign sh_a[4*gi +: 4]   = sh_a_reg[gi];
         assign sh_b[4*gi +: 4]   = sh_b_reg[gi];
         assign sh_and[4*gi +: 4] = sh_and_reg[gi];
      end
   endgenerate

   // The last nibble bypasses the shift registers straight into the FIFO.
   assign word_in.a = {bus.in_a, sh_a};
   assign word_in.b = {bus.in_b, sh_b};
   assign word_in.n = {bus.in_and, sh_and};

   always_comb begin
      count_next = count_reg;
      head_next  = head_reg;
      tail_next  = tail_reg;
      case ({push, pop})
         2'b10: begin
            if (count_reg == 2'd0) begin
               head_next = word_in;
            end else begin
               tail_next = word_in;
            end
            count_next = count_reg + 2'd1;
         end
         2'b01: begin
            if (full) begin
               head_next = tail_reg;
            end
            count_next = count_reg - 2'd1;
         end
         2'b11: begin
            if (full) begin
               head_next = tail_reg;
               tail_next = word_in;
            end else begin
               head_next = word_in;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
      end else begin
         count_reg <= count_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
      end
   end

`ifdef SWING_CHECK_EN
   logic err_reg;
   logic violation;

   assign violation = accept & (|(bus.in_and & ~(bus.in_a ^ bus.in_b)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_reg <= 1'b0;
      end else if (violation) begin
         err_reg <= 1'b1;
      end else if (err_clr) begin
         err_reg <= 1'b0;
      end
   end

   assign err = err_reg;
`else
   // No checker in this build; err_clr has no effect.
   assign err = err_clr & 1'b0;
`endif
endmodule

// File: tb/tb_swing_collector.sv
// Self-checking bench for swing_collector: table-driven words, directed corner sequences, random traffic.
module tb_swing_collector;
   localparam int NIBBLES = 8;
   localparam int W = 4 * NIBBLES;

`ifdef SWING_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] n;
   } word_t;

   // Nibble k of each lane is start + k*step (mod 16).
   typedef struct {
      logic [3:0]   a0;
      logic [3:0]   ad;
      logic [3:0]   b0;
      logic [3:0]   bd;
      logic [3:0]   n0;
      logic [3:0]   nd;
      logic [W-1:0] exp_a;
      logic [W-1:0] exp_b;
      logic [W-1:0] exp_n;
      logic         exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic err;
   logic err_clr = 1'b0;

   swing_collector_if #(.NIBBLES(NIBBLES)) bus ();

   swing_collector #(.NIBBLES(NIBBLES)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .err     (err),
      .err_clr (err_clr)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   int    words_out = 0;
   int    mcnt = 0;
   word_t sb[$];
   word_t mword;
   logic  use_exp = 1'b0;
   word_t exp_word;
   vec_t  vecs[5];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, sample 1ns later, update the model.
   task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] n,
                       input logic ordy, input logic ec, output logic acc);
      logic  exp_rdy;
      word_t w;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_and    = n;
      bus.out_ready = ordy;
      err_clr       = ec;
      #1;
      exp_rdy = !(mcnt == NIBBLES - 1 && sb.size() == 2 && !ordy);
      check("in_ready", W'(bus.in_ready), W'(exp_rdy));
      check("out_valid", W'(bus.out_valid), W'(sb.size() != 0));
      if (bus.out_valid && ordy && sb.size() != 0) begin
         w = sb.pop_front();
         check("out_a", bus.out_a, w.a);
         check("out_b", bus.out_b, w.b);
         check("out_and", bus.out_and, w.n);
         $display("word %0d: a=%h b=%h and=%h", words_out, bus.out_a, bus.out_b, bus.out_and);
         words_out++;
      end
      acc = v && bus.in_ready;
      if (acc) begin
         mword.a[4*mcnt +: 4] = a;
         mword.b[4*mcnt +: 4] = b;
         mword.n[4*mcnt +: 4] = n;
         if (mcnt == NIBBLES - 1) begin
            sb.push_back(use_exp ? exp_word : mword);
            mcnt = 0;
         end else begin
            mcnt++;
         end
      end
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] n, input logic ordy);
      logic acc;
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
         step(1'b1, a, b, n, ordy, 1'b0, acc);
      end
      check("accept_timeout", W'(acc), W'(1'b1));
   endtask

   task automatic idle(input int cycles, input logic ec);
      logic acc;
      for (int t = 0; t < cycles; t++) begin
         step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, ec, acc);
      end
   endtask

   task automatic drain();
      logic acc;
      for (int t = 0; t < 200 && sb.size() != 0; t++) begin
         step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, acc);
      end
      check("drain_empty", W'(sb.size()), '0);
   endtask

   task automatic send_random_word(input logic ordy);
      logic [3:0] a;
      logic [3:0] b;
      for (int k = 0; k < NIBBLES; k++) begin
         a = 4'($urandom);
         b = 4'($urandom);
         send(a, b, (a ^ b) & 4'($urandom), ordy);
      end
   endtask

   initial begin
      logic       acc;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] n;

      vecs[0] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h76543210, 32'h00000000, 32'h00000000, 1'b0};
      vecs[1] = '{4'h3, 4'h0, 4'h6, 4'h0, 4'h1, 4'h0, 32'h33333333, 32'h66666666, 32'h11111111, 1'b0};
      vecs[2] = '{4'hF, 4'hF, 4'h0, 4'h1, 4'h5, 4'h0, 32'h89ABCDEF, 32'h76543210, 32'h55555555, 1'b0};
      vecs[3] = '{4'hA, 4'h0, 4'h5, 4'h0, 4'hF, 4'h0, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0};
      vecs[4] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};

      bus.in_valid  = 1'b0;
      bus.in_a      = 4'h0;
      bus.in_b      = 4'h0;
      bus.in_and    = 4'h0;
      bus.out_ready = 1'b0;

      // Reset state.
      #12;
      check("rst_out_valid", W'(bus.out_valid), '0);
      check("rst_out_a", bus.out_a, '0);
      check("rst_out_b", bus.out_b, '0);
      check("rst_out_and", bus.out_and, '0);
      check("rst_err", W'(err), '0);
      check("rst_in_ready", W'(bus.in_ready), W'(1'b1));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_in_ready", W'(bus.in_ready), W'(1'b1));

      // Table-driven words.
      for (int i = 0; i < 5; i++) begin
         use_exp  = 1'b1;
         exp_word = '{vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_n};
         for (int k = 0; k < NIBBLES; k++) begin
            a = 4'(vecs[i].a0 + 4'(k) * vecs[i].ad);
            b = 4'(vecs[i].b0 + 4'(k) * vecs[i].bd);
            n = 4'(vecs[i].n0 + 4'(k) * vecs[i].nd);
            send(a, b, n, 1'b1);
         end
         use_exp = 1'b0;
         drain();
         check("table_err", W'(err), W'(vecs[i].exp_err));
      end

      // Backpressure: two words fill the FIFO, the third stalls on its last nibble.
      send_random_word(1'b0);
      send_random_word(1'b0);
      for (int k = 0; k < NIBBLES - 1; k++) begin
         send(4'(k), 4'(k + 1), 4'h0, 1'b0);
      end
      for (int t = 0; t < 3; t++) begin
         step(1'b1, 4'hC, 4'h3, 4'h1, 1'b0, 1'b0, acc);
         check("stall_no_accept", W'(acc), '0);
      end
      step(1'b1, 4'hC, 4'h3, 4'h1, 1'b1, 1'b0, acc);
      check("unstall_accept", W'(acc), W'(1'b1));
      drain();

      // Checker: sticky set, clear, and set-wins-over-clear.
      step(1'b1, 4'hF, 4'hF, 4'h1, 1'b1, 1'b0, acc);
      idle(1, 1'b0);
      check("err_set", W'(err), W'(CHK));
      idle(2, 1'b0);
      check("err_sticky", W'(err), W'(CHK));
      idle(1, 1'b1);
      idle(1, 1'b0);
      check("err_clr", W'(err), '0);
      step(1'b1, 4'hF, 4'hF, 4'h2, 1'b1, 1'b1, acc);
      idle(1, 1'b0);
      check("err_set_wins", W'(err), W'(CHK));
      idle(1, 1'b1);
      idle(1, 1'b0);
      check("err_clr2", W'(err), '0);
      for (int k = 2; k < NIBBLES; k++) begin
         send(4'(k), 4'h0, 4'h0, 1'b1);
      end
      drain();

      // Asynchronous reset mid-word with one word queued.
      send_random_word(1'b0);
      send(4'hF, 4'hF, 4'h4, 1'b0);
      for (int k = 1; k < 5; k++) begin
         send(4'(k), 4'h5, 4'h0, 1'b0);
      end
      check("pre_rst_valid", W'(bus.out_valid), W'(1'b1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      check("arst_out_valid", W'(bus.out_valid), '0);
      check("arst_out_a", bus.out_a, '0);
      check("arst_out_b", bus.out_b, '0);
      check("arst_out_and", bus.out_and, '0);
      check("arst_err", W'(err), '0);
      check("arst_in_ready", W'(bus.in_ready), W'(1'b1));
      sb.delete();
      mcnt = 0;
      @(negedge clk);
      reset = 1'b1;
      use_exp  = 1'b1;
      exp_word = '{32'hFEDCBA98, 32'h00000000, 32'h00000000};
      for (int k = 0; k < NIBBLES; k++) begin
         send(4'(k + 8), 4'h0, 4'h0, 1'b1);
      end
      use_exp = 1'b0;
      drain();

      // Random valid gaps and out_ready toggling.
      for (int wd = 0; wd < 100; wd++) begin
         for (int k = 0; k < NIBBLES; k++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            n = (a ^ b) & 4'($urandom);
            acc = 1'b0;
            for (int t = 0; t < 64 && !acc; t++) begin
               step(1'($urandom_range(0, 1)), a, b, n, 1'($urandom_range(0, 1)), 1'b0, acc);
            end
            check("rand_accept_timeout", W'(acc), W'(1'b1));
         end
      end
      drain();
      check("rand_err", W'(err), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/swing_collector.md
# swing_collector

Reassembly end of the nibble datapath. Consumes the per-cycle 4-bit triples (A, B, AND) produced by the nibble XOR/AND swing stage and packs NIBBLES consecutive accepted triples into word-wide A, B and AND results. Results are buffered in a 2-entry FIFO and presented on a valid/ready interface to the word-level consumer (hash/merge logic). An optional checker flags triples whose AND nibble is inconsistent with its A and B nibbles.

## Interface
- NIBBLES, 8, nibbles per word; word width W = 4*NIBBLES; legal range 2..16.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  triple present on in_a/in_b/in_and.
- in_ready  out  1  collector accepts the triple this cycle.
- in_a  in  4  A nibble.
- in_b  in  4  B nibble.
- in_and  in  4  AND nibble; by construction (A^B)&C.
- out_valid  out  1  head FIFO word valid.
- out_ready  in  1  consumer takes head word.
- out_a  out  W  packed A word.
- out_b  out  W  packed B word.
- out_and  out  W  packed AND word.
- err  out  1  sticky consistency error.
- err_clr  in  1  synchronous clear of err.

## Operation
- Accept: in_valid & in_ready.
- Packing is LSB-first: the k-th accepted nibble of a word (k = 0..NIBBLES-1) lands in bits [4k+3:4k] of all three words.
- Nibble counter cnt (0..NIBBLES-1) increments on accept and wraps to 0 on the last nibble. The last-nibble accept pushes {A, B, AND} (the shift contents plus the current nibble) into the FIFO.
- FIFO: 2 entries, registered outputs; out_* show the head entry.
  - Pop: out_valid & out_ready.
  - Push and pop in the same cycle are both legal when the FIFO is full.
- in_ready = 0 only when cnt == NIBBLES-1, the FIFO holds 2 entries, and out_ready = 0. Otherwise in_ready = 1, so partial nibbles are never stalled. in_ready depends combinationally on out_ready; this is intentional.
- When out_valid = 0, out_a, out_b and out_and hold their last value. Consumers ignore them in this state.
- Checker: on accept, if in_and & ~(in_a ^ in_b) != 0, then err is set on the next edge.
  - err stays set until err_clr.
  - If err_clr and a new violation occur in the same cycle, set wins.

## Timing
- Reset (reset = 0, asynchronous) drives the following; a partial word in flight is discarded and FIFO contents are lost:
  - out_valid = 0
  - out_a, out_b, out_and = 0
  - err = 0
  - cnt = 0
  - FIFO empty
- in_ready is 1 during reset and after release.
- Latency: out_valid rises on the edge that accepts the last nibble, i.e. it is visible the cycle after that nibble is presented. If the FIFO is empty, the word appears on out_* in the same cycle.
- Throughput: one nibble per cycle sustained with out_ready = 1, giving one word every NIBBLES cycles.
- FIFO full with out_ready held 0: nibbles 0..NIBBLES-2 of the next word are still accepted. The last nibble stalls with in_ready = 0 until out_ready = 1.
- Gaps on in_valid are arbitrary; cnt holds across idle cycles.

## Configuration
- SWING_CHECK_EN defined: consistency checker, err register and err_clr logic are built as described.
- SWING_CHECK_EN undefined: no checker logic; err is tied to 0 and err_clr is ignored. All other behaviour is identical.

## Test plan
- Reset then 8 accepts with in_a = 0..7, in_b = 0, in_and = 0, out_ready = 1 -> one out_valid pulse with out_a = 32'h76543210, out_b = 0, out_and = 0, err = 0.
- 8 triples a = 4'b0011, b = 4'b0110, and = 4'b0001 -> out_a = 32'h33333333, out_b = 32'h66666666, out_and = 32'h11111111, err = 0.
- out_ready = 0 for 3 words of continuous input:
  - words 1–2 fill the FIFO;
  - word 3 nibbles 0..6 are accepted, then in_ready = 0 on nibble 7;
  - raising out_ready pops word 1, accepts nibble 7 the same cycle, and all 3 words emerge in order, intact.
- Triple a = 4'b1111, b = 4'b1111, and = 4'b0001 (violation) -> err = 1 the next cycle and it stays 1. err_clr pulse -> err = 0. With SWING_CHECK_EN undefined, err stays 0.
- Assert reset after 5 nibbles with 1 word queued -> out_valid = 0 immediately and outputs are 0. After release, 8 new nibbles form a fresh word, and no stale nibbles appear in it.
- Random in_valid gaps with 50% out_ready toggling over 100 words -> output words match a reference packing model, with no loss or duplication.
